apb_mem_slave_p: RTL and testbench

Parametrised next-generation APB memory-mapped slave: register-file memory of DEPTH words, DATA_WIDTH bits each, behind a full APB3 handshake. Adds the following over the fixed 32x32 slave:
- programmable wait states via PREADY
- base-address window decode
- protocol-violation recovery
- optional byte strobes

Sits on the APB bus as a target for the UVM APB master agent; drop-in for single-slave benches.

---
 rtl/apb_mem_slave_p.sv | 179 +++++++++++++++++
 tb/tb_apb_mem_slave_p.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_p.sv
// APB3 register-file slave with programmable wait states, base-address window and error response.
// Define APB_PSTRB_EN to honour per-byte write strobes (PSTRB); otherwise writes update whole words.
module apb_mem_slave_p #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]            state_q, state_n, phase_c;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  write_q, write_n;
  logic                  addr_ok_q, addr_ok_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [DATA_WIDTH-1:0] prdata_n;
  logic                  pready_n, pslverr_n;

  logic [ADDR_WIDTH-1:0] offset_c;
  logic                  addr_ok_c;
  logic [IDX_W-1:0]      idx_c;
  logic [DATA_WIDTH-1:0] wr_word_c;
  logic                  wr_en_c;

  // Window decode; addresses below BASE_ADDR never wrap into the window
  assign offset_c  = PADDR - BASE_A;
  assign addr_ok_c = (PADDR >= BASE_A) && (offset_c < DEPTH_A);
  assign idx_c     = IDX_W'(offset_c);

`ifdef APB_PSTRB_EN
  logic [STRB_W-1:0] strb_q, strb_n;
`else
  logic unused_pstrb;
  assign unused_pstrb = ^PSTRB;
`endif

  // Bus phase of the current cycle: a fresh setup always wins, access continues only an open transfer
  always_comb begin
    phase_c = ST_IDLE;
    if (PSEL && !PENABLE) begin
      phase_c = ST_SETUP;
    end else if ((state_q == ST_ACCESS) && PSEL && PENABLE) begin
      phase_c = ST_ACCESS;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n   = ST_IDLE;
    cnt_n     = '0;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = PRDATA;
    write_n   = write_q;
    addr_ok_n = addr_ok_q;
    idx_n     = idx_q;
    wdata_n   = wdata_q;
`ifdef APB_PSTRB_EN
    strb_n    = strb_q;
`endif
    case (phase_c)
      ST_SETUP: begin
        state_n   = ST_ACCESS;
        cnt_n     = CNT_W'(WAIT_CYCLES);
        write_n   = PWRITE;
        addr_ok_n = addr_ok_c;
        idx_n     = idx_c;
        wdata_n   = PWDATA;
`ifdef APB_PSTRB_EN
        strb_n    = PSTRB;
`endif
        pready_n  = (WAIT_CYCLES == 0);
        pslverr_n = (WAIT_CYCLES == 0) && !addr_ok_c;
        if (!PWRITE) begin
          prdata_n = addr_ok_c ? mem_q[idx_c] : ERR_WORD;
        end
      end
      ST_ACCESS: begin
        // Completion cycle (cnt_q == 0) falls through to IDLE
        if (cnt_q != '0) begin
          state_n   = ST_ACCESS;
          cnt_n     = cnt_q - CNT_W'(1);
          pready_n  = (cnt_q == CNT_W'(1));
          pslverr_n = (cnt_q == CNT_W'(1)) && !addr_ok_q;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_ok_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      write_q   <= write_n;
      addr_ok_q <= addr_ok_n;
      idx_q     <= idx_n;
      wdata_q   <= wdata_n;
      PRDATA    <= prdata_n;
      PREADY    <= pready_n;
      PSLVERR   <= pslverr_n;
    end
  end

`ifdef APB_PSTRB_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      strb_q <= '0;
    end else begin
      strb_q <= strb_n;
    end
  end
`endif

  // Merge write data into the stored word
  always_comb begin
    wr_word_c = wdata_q;
`ifdef APB_PSTRB_EN
    wr_word_c = mem_q[idx_q];
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (strb_q[i]) begin
        wr_word_c[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
`endif
  end

  assign wr_en_c = (state_q == ST_ACCESS) && PREADY && PSEL && PENABLE && write_q && addr_ok_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[idx_q] <= wr_word_c;
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p: four instances (default, 3 waits, base 0x100, 2 waits)
// share one APB bus and are selected individually through their PSEL.
module tb_apb_mem_slave_p;

  logic        PCLK;
  logic        PRESET;
  logic [3:0]  psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] prdata [4];
  logic [3:0]  pready;
  logic [3:0]  pslverr;

  int checks = 0;
  int errors = 0;

`ifdef APB_PSTRB_EN
  localparam logic [31:0] EXP_STRB = 32'hFF34FF78;
`else
  localparam logic [31:0] EXP_STRB = 32'h12345678;
`endif

  apb_mem_slave_p u_def (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave_p #(.WAIT_CYCLES(3)) u_w3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave_p #(.BASE_ADDR(32'h100)) u_base (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  apb_mem_slave_p #(.WAIT_CYCLES(2)) u_w2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[3]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer on instance s; returns data/err sampled in the completion cycle
  task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int waits, output logic stable);
    logic [31:0] first;
    psel[s] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = st;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    first  = prdata[s];
    stable = 1'b1;
    waits  = 0;
    while (!pready[s] && waits < 40) begin
      @(posedge PCLK); #1;
      waits++;
      if (prdata[s] !== first) stable = 1'b0;
    end
    chk("pready_seen", 32'(pready[s]), 32'd1);
    rd = prdata[s];
    er = pslverr[s];
    @(posedge PCLK); #1;
    psel[s] = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_write(input string tag, input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input logic exp_err, input int exp_waits);
    logic [31:0] rd; logic er; int w; logic stb;
    xfer(s, 1'b1, a, d, st, rd, er, w, stb);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
  endtask

  task automatic do_read(input string tag, input int s, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_err, input int exp_waits);
    logic [31:0] rd; logic er; int w; logic stb;
    xfer(s, 1'b0, a, 32'h0, 4'hF, rd, er, w, stb);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
    chk({tag, "_stable"}, 32'(stb), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] rd; logic er; int w; logic stb;
    PRESET = 1'b1; psel = '0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    chk("rst_prdata", prdata[0], 32'h0);
    chk("rst_pready", 32'(pready[0]), 32'd0);
    chk("rst_pslverr", 32'(pslverr[0]), 32'd0);

    // Back-to-back write then read-after-write
    do_write("def_wr3", 0, 32'd3, 32'hA5A5_0001, 4'hF, 1'b0, 0);
    do_read("def_rd3", 0, 32'd3, 32'hA5A5_0001, 1'b0, 0);
    @(posedge PCLK); #1;
    chk("idle_pready", 32'(pready[0]), 32'd0);
    chk("idle_pslverr", 32'(pslverr[0]), 32'd0);
    chk("idle_prdata_hold", prdata[0], 32'hA5A5_0001);

    // PENABLE without a setup phase must be ignored
    psel[0] = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'd3; PWDATA = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      chk("nosetup_pready", 32'(pready[0]), 32'd0);
    end
    psel[0] = 1'b0; PENABLE = 1'b0;
    do_read("nosetup_rd3", 0, 32'd3, 32'hA5A5_0001, 1'b0, 0);

    // Out-of-window access
    do_write("oow_wr40", 0, 32'd40, 32'h1234_5678, 4'hF, 1'b1, 0);
    do_read("oow_rd40", 0, 32'd40, 32'hDEAD_BEEF, 1'b1, 0);
    for (int i = 0; i < 32; i++) begin
      do_read("scan", 0, 32'(i), (i == 3) ? 32'hA5A5_0001 : 32'h0, 1'b0, 0);
    end

    // Byte strobes
    do_write("strb_full", 0, 32'd7, 32'hFFFF_FFFF, 4'b1111, 1'b0, 0);
    do_write("strb_part", 0, 32'd7, 32'h1234_5678, 4'b0101, 1'b0, 0);
    do_read("strb_rd7", 0, 32'd7, EXP_STRB, 1'b0, 0);

    // Three wait states, data stable across ACCESS
    do_write("w3_wr10", 1, 32'd10, 32'hCAFE_0002, 4'hF, 1'b0, 3);
    do_read("w3_rd10", 1, 32'd10, 32'hCAFE_0002, 1'b0, 3);
    do_read("w3_rd32", 1, 32'd32, 32'hDEAD_BEEF, 1'b1, 3);
    do_read("w3_rd31", 1, 32'd31, 32'h0, 1'b0, 3);

    // Base-address window 0x100..0x11F
    do_write("base_wr0ff", 2, 32'h0FF, 32'h11, 4'hF, 1'b1, 0);
    do_write("base_wr100", 2, 32'h100, 32'h22, 4'hF, 1'b0, 0);
    do_write("base_wr11f", 2, 32'h11F, 32'h33, 4'hF, 1'b0, 0);
    do_read("base_rd100", 2, 32'h100, 32'h22, 1'b0, 0);
    do_read("base_rd11f", 2, 32'h11F, 32'h33, 1'b0, 0);
    do_read("base_rd120", 2, 32'h120, 32'hDEAD_BEEF, 1'b1, 0);
    do_read("base_rd000", 2, 32'h000, 32'hDEAD_BEEF, 1'b1, 0);
    do_read("base_rd11e", 2, 32'h11E, 32'h0, 1'b0, 0);

    // Abort by dropping PSEL during wait states
    psel[3] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd5; PWDATA = 32'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    psel[3] = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_pready", 32'(pready[3]), 32'd0);
    chk("abort_pslverr", 32'(pslverr[3]), 32'd0);
    @(posedge PCLK); #1;
    chk("abort_idle_pready", 32'(pready[3]), 32'd0);
    do_read("abort_rd5", 3, 32'd5, 32'h0, 1'b0, 2);

    // Reset asserted in the completion cycle of a write
    psel[3] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd5; PWDATA = 32'h66;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("rstmid_pready_before", 32'(pready[3]), 32'd1);
    PRESET = 1'b1;
    #2;
    chk("rstmid_pready", 32'(pready[3]), 32'd0);
    chk("rstmid_prdata_def", prdata[0], 32'h0);
    psel[3] = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    chk("rstmid_idle_pready", 32'(pready[3]), 32'd0);
    do_read("rstmid_rd5", 3, 32'd5, 32'h0, 1'b0, 2);
    do_read("rstmid_def_rd3", 0, 32'd3, 32'h0, 1'b0, 0);
    xfer(3, 1'b1, 32'd5, 32'h77, 4'hF, rd, er, w, stb);
    chk("post_wr5_waits", 32'(w), 32'd2);
    do_read("post_rd5", 3, 32'd5, 32'h77, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
